// File: rtl/tmds_link_controller.sv
// rtl/tmds_link_controller.sv - TMDS link bring-up sequencer and control-period token inserter
//
// Ports:
//   i_pixclk, i_reset_n       pixel clock and asynchronous active-low reset
//   i_mmcm_locked, i_enable   clock lock (pixclk domain) and link enable
//   i_de, i_hsync, i_vsync    video timing; syncs ride channel 0 as C0/C1
//   i_tmds_ch0..2             encoded video words (blue, green, red)
//   o_ch0..2, o_clk_ch        words to the data and clock serializers
//   o_ser_reset               active-high reset for all four serializers
//   o_link_up                 high while ACTIVE
//   o_state                   current state (0 IDLE .. 4 ACTIVE)
module tmds_link_controller #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SER_RST_CYCLES     = 16,
    parameter int WARMUP_CYCLES      = 64
) (
    input  logic       i_pixclk,
    input  logic       i_reset_n,
    input  logic       i_mmcm_locked,
    input  logic       i_enable,
    input  logic       i_de,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic [9:0] i_tmds_ch0,
    input  logic [9:0] i_tmds_ch1,
    input  logic [9:0] i_tmds_ch2,
    output logic [9:0] o_ch0,
    output logic [9:0] o_ch1,
    output logic [9:0] o_ch2,
    output logic [9:0] o_clk_ch,
    output logic       o_ser_reset,
    output logic       o_link_up,
    output logic [2:0] o_state
);

    localparam int MAX_A = (LOCK_STABLE_CYCLES > SER_RST_CYCLES) ? LOCK_STABLE_CYCLES : SER_RST_CYCLES;
    localparam int MAX_P = (MAX_A > WARMUP_CYCLES) ? MAX_A : WARMUP_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] SER_LAST    = CW'(SER_RST_CYCLES - 1);
    localparam logic [CW-1:0] WARMUP_LAST = CW'(WARMUP_CYCLES - 1);

    localparam logic [9:0] TOK_00   = 10'b1101010100;
    localparam logic [9:0] TOK_01   = 10'b0010101011;
    localparam logic [9:0] TOK_10   = 10'b0101010100;
    localparam logic [9:0] TOK_11   = 10'b1010101011;
    localparam logic [9:0] CLK_WORD = 10'b0000011111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOCK_WAIT = 3'd1,
        S_SER_RST   = 3'd2,
        S_WARMUP    = 3'd3,
        S_ACTIVE    = 3'd4
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_d;
    logic [9:0]    ch0_d, ch1_d, ch2_d;
    logic          ser_reset_d, link_up_d;

    function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
        case ({c1, c0})
            2'b00:   return TOK_00;
            2'b01:   return TOK_01;
            2'b10:   return TOK_10;
            default: return TOK_11;
        endcase
    endfunction

    // State and counter register
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_d;
        end
    end

    // Next-state logic; abort outranks every count completion
    always_comb begin
        next_state = S_IDLE;
        if (state != S_IDLE && (!i_mmcm_locked || !i_enable)) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      next_state = (i_enable && i_mmcm_locked) ? S_LOCK_WAIT : S_IDLE;
                S_LOCK_WAIT: next_state = (cnt >= LOCK_LAST) ? S_SER_RST : S_LOCK_WAIT;
                S_SER_RST:   next_state = (cnt >= SER_LAST) ? S_WARMUP : S_SER_RST;
                S_WARMUP:    next_state = (cnt >= WARMUP_LAST && !i_de) ? S_ACTIVE : S_WARMUP;
                S_ACTIVE:    next_state = S_ACTIVE;
                default:     next_state = S_IDLE;
            endcase
        end
        // Counter restarts on every state entry and saturates rather than wraps
        cnt_d = cnt;
        if (next_state != state || state == S_IDLE)
            cnt_d = '0;
        else if (cnt != '1)
            cnt_d = cnt + 1'b1;
    end

    // Output decode from next_state so outputs move on the same edge as the state
    always_comb begin
        ser_reset_d = 1'b1;
        link_up_d   = 1'b0;
        ch0_d       = TOK_00;
        ch1_d       = TOK_00;
        ch2_d       = TOK_00;
        case (next_state)
            S_WARMUP: begin
                ser_reset_d = 1'b0;
                ch0_d       = ctrl_token(i_vsync, i_hsync);
            end
            S_ACTIVE: begin
                ser_reset_d = 1'b0;
                link_up_d   = 1'b1;
                if (i_de) begin
                    ch0_d = i_tmds_ch0;
                    ch1_d = i_tmds_ch1;
                    ch2_d = i_tmds_ch2;
                end else begin
                    ch0_d = ctrl_token(i_vsync, i_hsync);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_ser_reset <= 1'b1;
            o_link_up   <= 1'b0;
            o_ch0       <= TOK_00;
            o_ch1       <= TOK_00;
            o_ch2       <= TOK_00;
        end else begin
            o_ser_reset <= ser_reset_d;
            o_link_up   <= link_up_d;
            o_ch0       <= ch0_d;
            o_ch1       <= ch1_d;
            o_ch2       <= ch2_d;
        end
    end

    assign o_state  = state;
    assign o_clk_ch = CLK_WORD;

endmodule

// File: tb/tb_tmds_link_controller.sv
// tb/tb_tmds_link_controller.sv - self-checking bench for tmds_link_controller
module tb_tmds_link_controller;

    localparam int L = 8;
    localparam int S = 4;
    localparam int W = 6;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] CLKW = 10'b0000011111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked, enable, de, hsync, vsync;
    logic [9:0] d0, d1, d2;
    logic [9:0] o_ch0, o_ch1, o_ch2, o_clk_ch;
    logic       o_ser_reset, o_link_up;
    logic [2:0] o_state;

    int checks = 0;
    int errors = 0;

    // Reference model: phase number and edges spent in that phase
    int         m_state = 0;
    int         m_age   = 0;
    logic [9:0] e_ch0 = T00, e_ch1 = T00, e_ch2 = T00;

    tmds_link_controller #(
        .LOCK_STABLE_CYCLES(L),
        .SER_RST_CYCLES(S),
        .WARMUP_CYCLES(W)
    ) dut (
        .i_pixclk(clk),
        .i_reset_n(rst_n),
        .i_mmcm_locked(locked),
        .i_enable(enable),
        .i_de(de),
        .i_hsync(hsync),
        .i_vsync(vsync),
        .i_tmds_ch0(d0),
        .i_tmds_ch1(d1),
        .i_tmds_ch2(d2),
        .o_ch0(o_ch0),
        .o_ch1(o_ch1),
        .o_ch2(o_ch2),
        .o_clk_ch(o_clk_ch),
        .o_ser_reset(o_ser_reset),
        .o_link_up(o_link_up),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] tok(input logic c1, input logic c0);
        logic [9:0] t [4];
        t[0] = T00; t[1] = T01; t[2] = T10; t[3] = T11;
        return t[{c1, c0}];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the inputs held across that edge
    task automatic model_edge();
        int ns;
        int need;
        if (m_state != 0 && (!locked || !enable)) begin
            ns = 0;
        end else begin
            ns = m_state;
            need = (m_state == 1) ? L : (m_state == 2) ? S : W;
            if (m_state == 0 && enable && locked) ns = 1;
            else if ((m_state == 1 || m_state == 2) && m_age + 1 >= need) ns = m_state + 1;
            else if (m_state == 3 && m_age + 1 >= need && !de) ns = 4;
        end
        m_age   = (ns != m_state) ? 0 : m_age + 1;
        m_state = ns;
        e_ch0 = T00; e_ch1 = T00; e_ch2 = T00;
        if (ns == 4 && de) begin
            e_ch0 = d0; e_ch1 = d1; e_ch2 = d2;
        end else if (ns >= 3) begin
            e_ch0 = tok(vsync, hsync);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_age = 0;
        e_ch0 = T00; e_ch1 = T00; e_ch2 = T00;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"}, 32'(o_state), 32'(m_state));
        chk({tag, ".ser_reset"}, 32'(o_ser_reset), 32'(m_state < 3));
        chk({tag, ".link_up"}, 32'(o_link_up), 32'(m_state == 4));
        chk({tag, ".ch0"}, 32'(o_ch0), 32'(e_ch0));
        chk({tag, ".ch1"}, 32'(o_ch1), 32'(e_ch1));
        chk({tag, ".ch2"}, 32'(o_ch2), 32'(e_ch2));
        chk({tag, ".clk_ch"}, 32'(o_clk_ch), 32'(CLKW));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".state"}, 32'(o_state), 32'd0);
        chk({tag, ".ser_reset"}, 32'(o_ser_reset), 32'd1);
        chk({tag, ".link_up"}, 32'(o_link_up), 32'd0);
        chk({tag, ".ch0"}, 32'(o_ch0), 32'(T00));
        chk({tag, ".ch1"}, 32'(o_ch1), 32'(T00));
        chk({tag, ".ch2"}, 32'(o_ch2), 32'(T00));
        chk({tag, ".clk_ch"}, 32'(o_clk_ch), 32'(CLKW));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        locked = 1'b0; enable = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        tick("idle");

        // Bring-up with de low: 8 LOCK_WAIT, 4 SER_RST, 6 WARMUP, then ACTIVE
        locked = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            tick("bringup");
            chk("bringup.state_seq", 32'(o_state),
                (i <= 8) ? 32'd1 : (i <= 12) ? 32'd2 : (i <= 18) ? 32'd3 : 32'd4);
            chk("bringup.ser_reset_seq", 32'(o_ser_reset), 32'(i <= 12));
            chk("bringup.link_up_seq", 32'(o_link_up), 32'(i == 19));
        end

        // Video words pass with one cycle latency
        de = 1'b1; d0 = 10'h2AA; d1 = 10'h155; d2 = 10'h3C3;
        tick("video");
        chk("video.ch0", 32'(o_ch0), 32'h2AA);
        chk("video.ch1", 32'(o_ch1), 32'h155);
        chk("video.ch2", 32'(o_ch2), 32'h3C3);
        de = 1'b0; hsync = 1'b1; vsync = 1'b0;
        tick("blank");
        chk("blank.ch0", 32'(o_ch0), 32'(T01));
        chk("blank.ch1", 32'(o_ch1), 32'(T00));
        chk("blank.ch2", 32'(o_ch2), 32'(T00));

        // Lock drop in ACTIVE
        locked = 1'b0; hsync = 1'b0;
        tick("active_drop");
        chk("active_drop.state", 32'(o_state), 32'd0);
        chk("active_drop.ser_reset", 32'(o_ser_reset), 32'd1);
        chk("active_drop.link_up", 32'(o_link_up), 32'd0);

        // Lock drop in LOCK_WAIT at count 5, then relock restarts the full count
        locked = 1'b1;
        for (int i = 0; i < 6; i++) tick("lw");
        locked = 1'b0;
        tick("lw_drop");
        chk("lw_drop.state", 32'(o_state), 32'd0);
        locked = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick("relock");
            chk("relock.state_seq", 32'(o_state), (i <= 8) ? 32'd1 : 32'd2);
        end

        // Enable drop on the final SER_RST cycle
        for (int i = 0; i < 3; i++) tick("sr");
        chk("sr_final.state", 32'(o_state), 32'd2);
        enable = 1'b0;
        tick("sr_drop");
        chk("sr_drop.state", 32'(o_state), 32'd0);
        enable = 1'b1;

        // WARMUP with de held high past count completion
        for (int i = 0; i < 13; i++) tick("to_warmup");
        chk("warmup.entry", 32'(o_state), 32'd3);
        de = 1'b1; d0 = 10'h0F0; d1 = 10'h00F; d2 = 10'h3FF;
        for (int i = 0; i < 10; i++) begin
            tick("warmup_de");
            chk("warmup_de.state", 32'(o_state), 32'd3);
            chk("warmup_de.no_video", 32'(o_ch1), 32'(T00));
        end
        de = 1'b0;
        tick("warmup_exit");
        chk("warmup_exit.state", 32'(o_state), 32'd4);

        // Randomized traffic with occasional lock/enable drops
        for (int i = 0; i < 600; i++) begin
            de = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
            d0 = 10'($urandom); d1 = 10'($urandom); d2 = 10'($urandom);
            locked = ($urandom_range(0, 63) != 0);
            enable = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 3) == 0) de = 1'b0;
            tick("rand");
        end

        // Async reset in the middle of ACTIVE
        locked = 1'b1; enable = 1'b1; de = 1'b0;
        n = 0;
        while (m_state != 4 && n < 60) begin
            tick("reacquire");
            n++;
        end
        chk("reacquire.reached_active", 32'(o_state), 32'd4);
        de = 1'b1; d0 = 10'h123; d1 = 10'h234; d2 = 10'h345;
        tick("pre_reset");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("async_reset");
        @(posedge clk);
        #1;
        check_reset_values("held_reset");
        rst_n = 1'b1;
        tick("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmds_link_controller.md
# tmds_link_controller

Sequencing and control-period controller in front of the three TMDS data-channel serializers and the TMDS clock channel of the HDMI TX path. It waits for a stable pixel/serial clock lock, holds the 10:1 serializers in reset for a defined time, then warms the link up with control tokens. Only then does it pass encoded video words. Outside active video it inserts the DVI control tokens that carry HSYNC/VSYNC, and it drops the link back to reset on any loss of lock or enable.

## Interface
Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive locked pixel clocks required before the serializer reset sequence starts (must be ≥1).
- SER_RST_CYCLES, 16: pixel clocks for which o_ser_reset is held in state SER_RST (must be ≥1).
- WARMUP_CYCLES, 64: pixel clocks of control tokens sent after reset release before video is allowed (must be ≥1).

Ports:
- i_pixclk  in  1  pixel clock, the serializer CLKDIV domain; the only clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_mmcm_locked  in  1  clock generator lock, already synchronous to i_pixclk.
- i_enable  in  1  link enable from configuration.
- i_de  in  1  data enable; 1 = active video.
- i_hsync  in  1  horizontal sync, carried as C0 on channel 0.
- i_vsync  in  1  vertical sync, carried as C1 on channel 0.
- i_tmds_ch0, i_tmds_ch1, i_tmds_ch2  in  10 each  TMDS-encoded video words for blue, green and red.
- o_ch0, o_ch1, o_ch2  out  10 each  words to the data-channel serializers.
- o_clk_ch  out  10  word to the clock-channel serializer.
- o_ser_reset  out  1  active-high reset for all four serializers.
- o_link_up  out  1  1 while in ACTIVE.
- o_state  out  3  current state encoding (status/debug).

## Operation
- Control tokens T(C1,C0):
  - T(0,0) = 10'b1101010100
  - T(0,1) = 10'b0010101011
  - T(1,0) = 10'b0101010100
  - T(1,1) = 10'b1010101011
- Channel 0 uses (C1,C0) = (i_vsync,i_hsync). Channels 1 and 2 always use T(0,0) outside video.
- o_clk_ch is constant 10'b0000011111 from reset onward.
- States, with o_state encoding:
  - IDLE=0. o_ser_reset=1. All channels output T(0,0). Go to LOCK_WAIT when i_enable && i_mmcm_locked.
  - LOCK_WAIT=1. o_ser_reset=1. All channels output T(0,0). Counter increments each cycle. Go to SER_RST after LOCK_STABLE_CYCLES cycles in this state.
  - SER_RST=2. o_ser_reset=1. All channels output T(0,0). Go to WARMUP after exactly SER_RST_CYCLES cycles.
  - WARMUP=3. o_ser_reset=0. ch0 outputs T(i_vsync,i_hsync); ch1 and ch2 output T(0,0); i_de is ignored. After WARMUP_CYCLES cycles, go to ACTIVE on the first cycle with i_de=0. The state stays in WARMUP while i_de=1.
  - ACTIVE=4. o_ser_reset=0, o_link_up=1. If i_de=1, o_chN = i_tmds_chN. If i_de=0, control tokens as in WARMUP.
- Abort: in any state other than IDLE, i_mmcm_locked=0 or i_enable=0 forces IDLE on the next edge. Abort has priority over every other transition and clears the counter.
- A single shared cycle counter is sized to clog2 of the largest parameter plus 1. It clears on every state entry and never wraps within a state.
- Encodings 5–7 are illegal and recover to IDLE.

## Timing
- All outputs are registered. Reset values:
  - o_ser_reset=1, o_link_up=0, o_state=0
  - o_ch0, o_ch1, o_ch2 = 10'b1101010100
  - o_clk_ch = 10'b0000011111
- Datapath latency: inputs sampled at edge k appear on o_ch* after edge k; exactly 1 cycle.
- State outputs (o_ser_reset, o_link_up, o_state) change on the same edge as the state register.
  - o_ser_reset falls on the edge that enters WARMUP.
  - o_link_up rises on the edge that enters ACTIVE.
- From the edge that enters LOCK_WAIT with lock held, minimum time to ACTIVE is LOCK_STABLE_CYCLES + SER_RST_CYCLES + WARMUP_CYCLES edges.
- Asynchronous reset asserted mid-operation immediately forces all reset values. On release, the block starts in IDLE.
- Lock lost on the same edge a state count completes: abort wins and the next state is IDLE.

## Test plan
Bench parameters are LOCK_STABLE_CYCLES=8, SER_RST_CYCLES=4, WARMUP_CYCLES=6.
- Bring-up: reset released, then locked=1, enable=1, de=0 held. Required:
  - state goes 0→1, then 2 after 8 cycles, then 3 after 4 more, then 4 after 6 more.
  - o_ser_reset is high for exactly 12 cycles after leaving IDLE.
  - o_link_up=1 at cycle 18 after the IDLE exit.
- Video/blank mux in ACTIVE:
  - de=1 with ch0/1/2 inputs = 10'h2AA / 10'h155 / 10'h3C3 → same values on o_ch* one cycle later.
  - de=0, hsync=1, vsync=0 → o_ch0=10'b0010101011 and o_ch1=o_ch2=10'b1101010100.
- WARMUP with de=1 at count completion: the state remains 3 until de falls, then goes to 4 on the next edge. No video word is emitted before ACTIVE.
- Lock drop:
  - locked→0 in LOCK_WAIT at count 5 → IDLE next edge, and a relock restarts the full 8-cycle count.
  - locked→0 in ACTIVE → IDLE, with o_ser_reset=1 and o_link_up=0 on the same edge.
- Enable drop in SER_RST on its final cycle → IDLE, not WARMUP.
- Async reset asserted mid-ACTIVE → all outputs show reset values before the next clock edge; o_clk_ch stays 10'b0000011111 throughout.
